// File: rtl/bcd_display_formatter.sv
// Iterative binary-to-BCD converter (double dabble, one bit per clock) feeding a
// six-digit seven-segment driver, with registered outputs and leading-zero blanking.
module bcd_display_formatter #(
    parameter int BIN_WIDTH           = 20,
    parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIN_WIDTH-1:0] in_value,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [23:0]          data,
    output logic [5:0]           digit_enable_mask,
    output logic                 overflow,
    output logic                 done
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [23:0]          bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_pending_q, ovf_pending_d;
    logic [23:0]          data_q, data_d;
    logic [5:0]           mask_q, mask_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;

    logic [23:0]             bcd_adj;
    logic [24+BIN_WIDTH-1:0] shifted;
    logic [5:0]              blank_mask;
    logic                    seen_nonzero;
    logic [31:0]             in_ext;

    assign in_ext = 32'(in_value);

    // Add-3 correction on every nibble that would exceed 9 after doubling.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // A digit is shown once any digit at or above it is nonzero; digit 0 always shows.
    always_comb begin
        blank_mask   = '0;
        seen_nonzero = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            seen_nonzero  = seen_nonzero | (|bcd_q[4*i +: 4]);
            blank_mask[i] = seen_nonzero;
        end
        blank_mask[0] = 1'b1;
    end

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        bin_d         = bin_q;
        bcd_d         = bcd_q;
        cnt_d         = cnt_q;
        ovf_pending_d = ovf_pending_q;
        data_d        = data_q;
        mask_d        = mask_q;
        overflow_d    = overflow_q;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d         = in_value;
                    bcd_d         = '0;
                    cnt_d         = CNT_W'(BIN_WIDTH);
                    ovf_pending_d = (in_ext > 32'd999999);
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = shifted[24+BIN_WIDTH-1 -: 24];
                bin_d = shifted[BIN_WIDTH-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (ovf_pending_q) begin
                    data_d     = 24'h999999;
                    mask_d     = 6'b111111;
                    overflow_d = 1'b1;
                end else begin
                    data_d     = bcd_q;
                    mask_d     = BLANK_LEADING_ZEROS ? blank_mask : 6'b111111;
                    overflow_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            data_q        <= 24'h000000;
            mask_q        <= 6'b000001;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            ovf_pending_q <= ovf_pending_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign data              = data_q;
    assign digit_enable_mask = mask_q;
    assign overflow          = overflow_q;
    assign done              = done_q;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Scoreboard bench for bcd_display_formatter: three instances (default, no blanking,
// 8-bit input) driven by directed steps, with results checked when done pulses.
module tb_bcd_display_formatter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [19:0] in_val0, in_val1;
    logic [7:0]  in_val2;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [23:0] data_o    [3];
    logic [5:0]  mask_o    [3];
    logic        ovf_o     [3];
    logic        done_o    [3];

    bcd_display_formatter u_dut0 (
        .clk(clk), .reset(reset), .in_value(in_val0), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .data(data_o[0]), .digit_enable_mask(mask_o[0]),
        .overflow(ovf_o[0]), .done(done_o[0])
    );

    bcd_display_formatter #(.BLANK_LEADING_ZEROS(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .in_value(in_val1), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .data(data_o[1]), .digit_enable_mask(mask_o[1]),
        .overflow(ovf_o[1]), .done(done_o[1])
    );

    bcd_display_formatter #(.BIN_WIDTH(8)) u_dut2 (
        .clk(clk), .reset(reset), .in_value(in_val2), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .data(data_o[2]), .digit_enable_mask(mask_o[2]),
        .overflow(ovf_o[2]), .done(done_o[2])
    );

    typedef struct packed {
        logic [23:0] data;
        logic [5:0]  mask;
        logic        ovf;
    } res_t;

    localparam res_t RESET_RES = '{data: 24'h000000, mask: 6'b000001, ovf: 1'b0};

    res_t sb[$];
    res_t held[3];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result from decimal arithmetic rather than shift-add.
    function automatic res_t model(input int idx, input int v);
        res_t r;
        int   p;
        if (v > 999999) begin
            r = '{data: 24'h999999, mask: 6'b111111, ovf: 1'b1};
        end else begin
            r.ovf = 1'b0;
            p     = 1;
            for (int i = 0; i < 6; i++) begin
                r.data[4*i +: 4] = 4'((v / p) % 10);
                r.mask[i]        = (idx == 1) || (i == 0) || (v >= p);
                p                = p * 10;
            end
        end
        return r;
    endfunction

    task automatic drive(input int idx, input logic valid, input int v);
        case (idx)
            0:       in_val0 = 20'(v);
            1:       in_val1 = 20'(v);
            default: in_val2 = 8'(v);
        endcase
        in_valid[idx] = valid;
    endtask

    task automatic accept(input int idx, input int v);
        check("ready_idle", 32'(in_ready[idx]), 32'd1);
        drive(idx, 1'b1, v);
        sb.push_back(model(idx, v));
        @(negedge clk);
        drive(idx, 1'b0, v ^ 32'h5A5);
        check("ready_busy", 32'(in_ready[idx]), 32'd0);
    endtask

    task automatic compare_result(input int idx);
        res_t e;
        e = sb.pop_front();
        check("data", 32'(data_o[idx]), 32'(e.data));
        check("mask", 32'(mask_o[idx]), 32'(e.mask));
        check("overflow", 32'(ovf_o[idx]), 32'(e.ovf));
        held[idx] = e;
    endtask

    task automatic wait_done(input int idx, input int lat);
        int cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done_o[idx]) break;
            check("hold", {data_o[idx], mask_o[idx], ovf_o[idx], in_ready[idx]},
                  {held[idx].data, held[idx].mask, held[idx].ovf, 1'b0});
        end
        check("latency", 32'(cyc), 32'(lat));
        check("ready_at_done", 32'(in_ready[idx]), 32'd1);
        if (sb.size() > 0) compare_result(idx);
        @(negedge clk);
        check("done_pulse", 32'(done_o[idx]), 32'd0);
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 3; i++) begin
            check("rst_outputs", {data_o[i], mask_o[i], ovf_o[i], done_o[i]},
                  {24'h000000, 6'b000001, 1'b0, 1'b0});
            check("rst_ready", 32'(in_ready[i]), 32'd1);
            held[i] = RESET_RES;
        end
    endtask

    initial begin
        int   v;
        logic any_done;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 0);
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // First conversion on the first edge after reset; outputs held until E21.
        accept(0, 123456);
        wait_done(0, 21);

        accept(0, 42);      wait_done(0, 21);
        accept(0, 0);       wait_done(0, 21);
        accept(0, 100000);  wait_done(0, 21);
        accept(0, 20'hFFFFF); wait_done(0, 21);
        accept(0, 7);       wait_done(0, 21);

        // in_valid held high with a new value every cycle: accepts only at E0 and E22.
        for (int c = 0; c <= 44; c++) begin
            check("t4_ready", 32'(in_ready[0]), 32'(c == 0 || c == 22 || c == 44));
            check("t4_done", 32'(done_o[0]), 32'(c == 22 || c == 44));
            if (done_o[0] && sb.size() > 0) compare_result(0);
            if (c == 44) begin
                drive(0, 1'b0, 0);
            end else begin
                v = int'($urandom_range(0, 20'hFFFFF));
                drive(0, 1'b1, v);
                if (c == 0 || c == 22) sb.push_back(model(0, v));
            end
            @(negedge clk);
        end

        // Reset at E10 of a conversion discards it.
        accept(0, 999999);
        void'(sb.pop_back());
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state();
        any_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            any_done = any_done | done_o[0];
        end
        check("no_done_after_reset", 32'(any_done), 32'd0);
        check("outputs_after_reset", {data_o[0], mask_o[0], ovf_o[0], in_ready[0]},
              {24'h000000, 6'b000001, 1'b0, 1'b1});
        accept(0, 55);
        wait_done(0, 21);

        accept(1, 42);
        wait_done(1, 21);
        accept(2, 255);
        wait_done(2, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_formatter.md
# bcd_display_formatter

Converts an unsigned binary value into six packed BCD digits, plus a leading-zero blanking mask, for the `_7segment_display_driver` that sits directly downstream. `data` connects to the driver's `data` input and `digit_enable_mask` connects to the driver's `digit_enable_mask` input. Conversion is iterative shift-add-3 (double dabble), one bit per clock, behind a valid/ready input handshake. The outputs are registered and hold steady between conversions, so the display never shows intermediate values.

## Interface
- `BIN_WIDTH`, 20: width of the binary input, legal range 1..20.
- `BLANK_LEADING_ZEROS`, 1: when 1, leading zero digits are masked off; when 0, `digit_enable_mask` is always 6'b111111.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_value`  in  BIN_WIDTH  unsigned binary value to convert.
- `in_valid`  in  1  `in_value` is presented.
- `in_ready`  out  1  block is idle and accepts on this cycle.
- `data`  out  24  packed BCD; digit 5 is in [23:20] and digit 0 is in [3:0].
- `digit_enable_mask`  out  6  bit i enables digit i.
- `overflow`  out  1  last accepted value exceeded 999999.
- `done`  out  1  single-cycle pulse when new outputs are presented.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: BIN_WIDTH iterations.
  - FINISH: one cycle.
- Accept occurs on an edge where `in_valid`&&`in_ready`. On that edge:
  - Latch `in_value` into the binary shift register.
  - Clear the 24-bit BCD accumulator.
  - Load the iteration counter with BIN_WIDTH.
  - Latch `ovf_pending` = (`in_value` > 999999).
  - Go to SHIFT.
- Each SHIFT edge:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - The counter decrements. The edge that performs the last shift moves to FINISH.
- FINISH edge updates `data`, `digit_enable_mask` and `overflow`, pulses `done`, and returns to IDLE.
- Overflow handling: `data`=24'h999999, `digit_enable_mask`=6'b111111, `overflow`=1.
- Blanking (BLANK_LEADING_ZEROS=1):
  - Bit i = 1 if i==0, or if any of digits i..5 is nonzero.
  - Digit 0 is always shown, so a value of 0 displays "0".
- `in_value` and `in_valid` are ignored outside IDLE. A value change mid-conversion has no effect.
- Outputs change only on FINISH edges and on reset.
- Reset, whether idle or mid-conversion:
  - Next state is IDLE and the conversion is discarded; no `done` follows.
  - `data`=24'h000000, `digit_enable_mask`=6'b000001, `overflow`=0, `done`=0.
  - Inputs are ignored on the reset edge.
- Decimal points are not handled here. The top level drives `decimal_point_enable_mask` directly.

## Timing
- Call the accept edge E0. SHIFT edges are E1..E(BIN_WIDTH). FINISH is edge E(BIN_WIDTH+1), which is E21 at the default.
- New outputs and `done`=1 are visible in the cycle after E(BIN_WIDTH+1). `done` is low again after the next edge.
- `in_ready` is low from after E0 until after E(BIN_WIDTH+1). It is combinational from state, equal to (state==IDLE).
- The earliest next accept is E(BIN_WIDTH+2). With `in_valid` held high, accepts occur every BIN_WIDTH+2 cycles (22 at the default).
- After reset deasserts, `in_ready`=1 immediately. An accept is possible on the first edge with `reset`=0.
- No combinational path from inputs to `data`, `digit_enable_mask`, `overflow` or `done`.

## Test plan
- 123456 accepted at E0 -> `done` pulses after E21 only; `data`=24'h123456, `digit_enable_mask`=6'b111111, `overflow`=0. Outputs unchanged from reset values at E1..E20.
- Sequence 42, then 0, then 100000 -> `data`=24'h000042 with mask 6'b000011. Then `data`=24'h000000 with mask 6'b000001. Then `data`=24'h100000 with mask 6'b111111 (inner zeros shown).
- 1048575 (20'hFFFFF) -> `data`=24'h999999, mask 6'b111111, `overflow`=1. A following 7 gives `data`=24'h000007, mask 6'b000001, `overflow`=0.
- `in_valid` held high with `in_value` changing every cycle -> accepts only at E0 and E22. Each result matches the value sampled at its accept edge. `in_ready` is low in between.
- `reset` pulsed at E10 of a conversion of 999999 -> no `done`; outputs are 24'h000000 / 6'b000001 / 0. A fresh accept of 55 completes normally with `data`=24'h000055 and mask 6'b000011.
- BLANK_LEADING_ZEROS=0 with 42 -> `data`=24'h000042, mask 6'b111111. With BIN_WIDTH=8 and 255 -> `done` after E9, `data`=24'h000255.
